// File: rtl/stacker_pkg.sv
// Shared constants and lane-mapping helper for the word stacker.
package stacker_pkg;

    localparam int STACKER_IN_W  = 32;
    localparam int STACKER_RATIO = 4;

    // Maps the beat counter to the output lane the beat lands in.
    function automatic int unsigned lane_idx(input int unsigned cnt,
                                             input bit          msb_first,
                                             input int unsigned ratio);
        return msb_first ? (ratio - 1 - cnt) : cnt;
    endfunction

endpackage

// File: rtl/word_stacker.sv
// Stream upsizer: packs RATIO narrow beats into one wide word, with a
// one-word skid (acc held as pending) so a ready downstream sees full rate.
module word_stacker
    import stacker_pkg::*;
#(
    parameter int IN_W      = STACKER_IN_W,
    parameter int RATIO     = STACKER_RATIO,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  enable_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [IN_W-1:0]       data_i,
    input  logic                  last_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [IN_W*RATIO-1:0] data_o,
    output logic [RATIO-1:0]      keep_o,
    output logic                  last_o
);

    localparam int OUT_W = IN_W * RATIO;
    localparam int CNT_W = $clog2(RATIO);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    logic [OUT_W-1:0] acc_d, acc_q;
    logic [RATIO-1:0] acc_keep_d, acc_keep_q;
    logic             acc_last_d, acc_last_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             pend_d, pend_q;
    logic [OUT_W-1:0] out_d, out_q;
    logic [RATIO-1:0] out_keep_d, out_keep_q;
    logic             out_last_d, out_last_q;
    logic             valid_d, valid_q;

    logic             fire_in, fire_out, out_free, complete, load_out;
    int unsigned      lane;
    logic [OUT_W-1:0] merged_data;
    logic [RATIO-1:0] merged_keep;

    assign ready_o  = enable_i & ~pend_q;
    assign valid_o  = enable_i & valid_q;
    assign fire_in  = valid_i & ready_o;
    assign fire_out = valid_o & ready_i;
    assign out_free = ~valid_q | ready_i;
    assign complete = fire_in & ((cnt_q == CNT_LAST) | last_i);

    assign data_o = out_q;
    assign keep_o = out_keep_q;
    assign last_o = out_last_q;

    // Accumulator with the incoming beat already dropped into its lane.
    always_comb begin
        lane        = lane_idx(32'(cnt_q), MSB_FIRST, 32'(RATIO));
        merged_data = acc_q;
        merged_keep = acc_keep_q;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (lane == i) begin
                merged_data[i*IN_W +: IN_W] = data_i;
                merged_keep[i]              = 1'b1;
            end
        end
    end

    always_comb begin
        acc_d      = acc_q;
        acc_keep_d = acc_keep_q;
        acc_last_d = acc_last_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        out_d      = out_q;
        out_keep_d = out_keep_q;
        out_last_d = out_last_q;
        valid_d    = valid_q;
        load_out   = 1'b0;

        if (clr_i) begin
            acc_d      = '0;
            acc_keep_d = '0;
            acc_last_d = 1'b0;
            cnt_d      = '0;
            pend_d     = 1'b0;
            out_d      = '0;
            out_keep_d = '0;
            out_last_d = 1'b0;
            valid_d    = 1'b0;
        end else if (enable_i) begin
            if (pend_q) begin
                // Input side is stalled; only the held word can move.
                if (out_free) begin
                    out_d      = acc_q;
                    out_keep_d = acc_keep_q;
                    out_last_d = acc_last_q;
                    valid_d    = 1'b1;
                    pend_d     = 1'b0;
                    acc_d      = '0;
                    acc_keep_d = '0;
                    acc_last_d = 1'b0;
                    load_out   = 1'b1;
                end
            end else if (fire_in) begin
                if (complete) begin
                    cnt_d = '0;
                    if (out_free) begin
                        out_d      = merged_data;
                        out_keep_d = merged_keep;
                        out_last_d = last_i;
                        valid_d    = 1'b1;
                        acc_d      = '0;
                        acc_keep_d = '0;
                        acc_last_d = 1'b0;
                        load_out   = 1'b1;
                    end else begin
                        acc_d      = merged_data;
                        acc_keep_d = merged_keep;
                        acc_last_d = last_i;
                        pend_d     = 1'b1;
                    end
                end else begin
                    acc_d      = merged_data;
                    acc_keep_d = merged_keep;
                    cnt_d      = cnt_q + CNT_W'(1);
                end
            end

            // Drained output register is zeroed so stale data never lingers.
            if (fire_out && !load_out) begin
                valid_d    = 1'b0;
                out_d      = '0;
                out_keep_d = '0;
                out_last_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q      <= '0;
            acc_keep_q <= '0;
            acc_last_q <= 1'b0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            out_q      <= '0;
            out_keep_q <= '0;
            out_last_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            acc_keep_q <= acc_keep_d;
            acc_last_q <= acc_last_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            out_q      <= out_d;
            out_keep_q <= out_keep_d;
            out_last_q <= out_last_d;
            valid_q    <= valid_d;
        end
    end

endmodule
